// File: rtl/regfile_sequencer.sv
// Register-file strobe sequencer: runs one decoded command at a time as
// a short state sequence (strobe, memory-load wait, or two-step move).
module regfile_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_ra,
  input  logic [2:0] cmd_rb,
  output logic       mem_req,
  input  logic       mem_valid,
  output logic       cpyin,
  output logic       cpyout,
  output logic       memLoad,
  output logic       regWrite,
  output logic [2:0] reg_sel,
  output logic       wd_sel,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEMWAIT,
    MV_IN,
    MV_OUT,
    FAULT
  } state_t;

  localparam logic [2:0] OP_CPYIN  = 3'b001;
  localparam logic [2:0] OP_CPYOUT = 3'b010;
  localparam logic [2:0] OP_ALU    = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_MOVE   = 3'b101;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [2:0] op;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [7:0] cnt;
  logic       accept;

  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op  <= '0;
      ra  <= '0;
      rb  <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        op <= cmd_op;
        ra <= cmd_ra;
        rb <= cmd_rb;
      end
      if (accept) begin
        cnt <= '0;
      end else if (state == MEMWAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD:      next_state = MEMWAIT;
            OP_MOVE:      next_state = MV_IN;
            3'b110,
            3'b111:       next_state = FAULT;
            default:      next_state = EXEC;
          endcase
        end
      end
      // a late mem_valid on the timeout edge still completes the load
      MEMWAIT: begin
        if (mem_valid) begin
          next_state = EXEC;
        end else if (cnt == WAIT_LAST) begin
          next_state = FAULT;
        end
      end
      MV_IN:   next_state = MV_OUT;
      EXEC,
      MV_OUT,
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    cpyin     = 1'b0;
    cpyout    = 1'b0;
    memLoad   = 1'b0;
    regWrite  = 1'b0;
    reg_sel   = 3'd0;
    wd_sel    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: cmd_ready = 1'b1;
      EXEC: begin
        done = 1'b1;
        unique case (1'b1)
          (op == OP_CPYIN): begin
            regWrite = 1'b1;
            cpyin    = 1'b1;
            reg_sel  = ra;
          end
          (op == OP_CPYOUT): begin
            regWrite = 1'b1;
            cpyout   = 1'b1;
            reg_sel  = ra;
          end
          (op == OP_ALU): begin
            regWrite = 1'b1;
          end
          (op == OP_LOAD): begin
            regWrite = 1'b1;
            memLoad  = 1'b1;
            wd_sel   = 1'b1;
            reg_sel  = ra;
          end
          default: ;
        endcase
      end
      MEMWAIT: begin
        mem_req = 1'b1;
        wd_sel  = 1'b1;
        reg_sel = ra;
      end
      MV_IN: begin
        regWrite = 1'b1;
        cpyin    = 1'b1;
        reg_sel  = ra;
      end
      MV_OUT: begin
        regWrite = 1'b1;
        cpyout   = 1'b1;
        reg_sel  = rb;
        done     = 1'b1;
      end
      FAULT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file driven by the
// DUT strobes is compared against a command-level architectural model.
module tb_regfile_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_ra;
  logic [2:0] cmd_rb;
  logic       mem_req;
  logic       mem_valid;
  logic       cpyin;
  logic       cpyout;
  logic       memLoad;
  logic       regWrite;
  logic [2:0] reg_sel;
  logic       wd_sel;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [15:0] tb_regs [8];
  logic [15:0] tb_res;
  logic [15:0] ref_regs [8];
  logic [15:0] ref_res;
  logic [15:0] alu_data;
  logic [15:0] mem_data;
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [15:0] pl_val;

  regfile_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .mem_req   (mem_req),
    .mem_valid (mem_valid),
    .cpyin     (cpyin),
    .cpyout    (cpyout),
    .memLoad   (memLoad),
    .regWrite  (regWrite),
    .reg_sel   (reg_sel),
    .wd_sel    (wd_sel),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // register file writes land on the negedge, mid strobe cycle
  always @(negedge clk) begin
    if (pl_en) begin
      if (pl_idx == 4'd8) tb_res <= pl_val;
      else tb_regs[pl_idx[2:0]] <= pl_val;
    end else if (regWrite) begin
      if (cpyin) tb_res <= tb_regs[reg_sel];
      else if (cpyout) tb_regs[reg_sel] <= tb_res;
      else if (memLoad) tb_regs[reg_sel] <= wd_sel ? mem_data : alu_data;
      else tb_res <= wd_sel ? mem_data : alu_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs(input bit with_sel);
    return {cmd_ready, mem_req, cpyin, cpyout, memLoad, regWrite,
            wd_sel, done, err, with_sel ? reg_sel : 3'd0};
  endfunction

  function automatic logic [11:0] mk(input bit rdy, input bit req,
                                     input bit ci, input bit co,
                                     input bit ml, input bit rw,
                                     input bit wd, input bit dn,
                                     input bit er, input logic [2:0] sel);
    return {rdy, req, ci, co, ml, rw, wd, dn, er, sel};
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 8; i++)
      check($sformatf("r%0d", i), 32'(tb_regs[i]), 32'(ref_regs[i]));
    check("res", 32'(tb_res), 32'(ref_res));
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    pl_en  = 1'b1;
    pl_idx = 4'(idx);
    pl_val = val;
    @(negedge clk);
    #1 pl_en = 1'b0;
    if (idx == 8) ref_res = val;
    else ref_regs[idx] = val;
    @(posedge clk);
    #1;
  endtask

  // k: cycles after entering the wait before mem_valid is sampled high
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] ra,
                         input logic [2:0] rb, input int k,
                         input logic [15:0] md);
    int mw;
    int n;
    bit ok;
    bit isld;
    bit ws;
    logic [11:0] e;
    isld = (op == 3'd4);
    ok = (k < TMO);
    mw = isld ? (ok ? k + 1 : TMO) : 0;
    n = isld ? mw + 1 : (op == 3'd5 ? 2 : 1);
    mem_data = md;
    alu_data = 16'($urandom);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_ra = ra;
    cmd_rb = rb;
    mem_valid = 1'($urandom);
    @(negedge clk);
    check("idle", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    @(posedge clk);
    #1;
    for (int c = 1; c <= n; c++) begin
      cmd_valid = 1'($urandom);
      cmd_op = 3'($urandom);
      cmd_ra = 3'($urandom);
      cmd_rb = 3'($urandom);
      if (isld && c <= mw) mem_valid = (c == k + 1);
      else mem_valid = 1'($urandom);
      ws = 1'b0;
      e = '0;
      if (isld) begin
        if (c <= mw) begin
          e = mk(0,1,0,0,0,0,1,0,0,ra);
          ws = 1'b1;
        end else if (ok) begin
          e = mk(0,0,0,0,1,1,1,1,0,ra);
          ws = 1'b1;
        end else begin
          e = mk(0,0,0,0,0,0,0,1,1,3'd0);
        end
      end else begin
        case (op)
          3'd0: e = mk(0,0,0,0,0,0,0,1,0,3'd0);
          3'd1: begin e = mk(0,0,1,0,0,1,0,1,0,ra); ws = 1'b1; end
          3'd2: begin e = mk(0,0,0,1,0,1,0,1,0,ra); ws = 1'b1; end
          3'd3: e = mk(0,0,0,0,0,1,0,1,0,3'd0);
          3'd5: begin
            ws = 1'b1;
            if (c == 1) e = mk(0,0,1,0,0,1,0,0,0,ra);
            else e = mk(0,0,0,1,0,1,0,1,0,rb);
          end
          default: e = mk(0,0,0,0,0,0,0,1,1,3'd0);
        endcase
      end
      @(negedge clk);
      check($sformatf("op%0d_c%0d", op, c), 32'(outs(ws)), 32'(e));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    case (op)
      3'd1: ref_res = ref_regs[ra];
      3'd2: ref_regs[ra] = ref_res;
      3'd3: ref_res = alu_data;
      3'd4: if (ok) ref_regs[ra] = mem_data;
      3'd5: begin
        ref_res = ref_regs[ra];
        ref_regs[rb] = ref_res;
      end
      default: ;
    endcase
    check_regs();
  endtask

  task automatic reset_mid_move();
    preload(1, 16'h5A5A);
    preload(4, 16'h0F0F);
    cmd_valid = 1'b1;
    cmd_op = 3'd5;
    cmd_ra = 3'd1;
    cmd_rb = 3'd4;
    mem_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("mv_in", 32'(outs(1)), 32'(mk(0,0,1,0,0,1,0,0,0,3'd1)));
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    ref_res = ref_regs[1];
    @(posedge clk);
    #1 check("rst_hold", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_rel", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    @(posedge clk);
    #1;
    check_regs();
    check("r4_kept", 32'(tb_regs[4]), 32'h0F0F);
    check("res_r1", 32'(tb_res), 32'h5A5A);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_ra = '0;
    cmd_rb = '0;
    mem_valid = 1'b0;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_val = '0;
    alu_data = '0;
    mem_data = '0;
    #12;
    check("rst_on", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_off", 32'(outs(1)), 32'(mk(1,0,0,0,0,0,0,0,0,3'd0)));
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) preload(i, 16'($urandom));

    preload(3, 16'h1234);
    run_cmd(3'd1, 3'd3, 3'd0, 0, 16'h0);
    check("res_cpyin", 32'(tb_res), 32'h1234);

    preload(2, 16'hBEEF);
    run_cmd(3'd5, 3'd2, 3'd5, 0, 16'h0);
    check("r5_move", 32'(tb_regs[5]), 32'hBEEF);
    check("res_move", 32'(tb_res), 32'hBEEF);
    check("r2_move", 32'(tb_regs[2]), 32'hBEEF);

    run_cmd(3'd4, 3'd7, 3'd0, 3, 16'h00A5);
    check("r7_load", 32'(tb_regs[7]), 32'h00A5);

    run_cmd(3'd4, 3'd6, 3'd0, 99, 16'hDEAD);
    run_cmd(3'd4, 3'd0, 3'd0, TMO - 1, 16'hC0DE);
    run_cmd(3'd6, 3'd1, 3'd2, 0, 16'h0);
    run_cmd(3'd3, 3'd0, 3'd0, 0, 16'h0);
    run_cmd(3'd4, 3'd5, 3'd0, 0, 16'h7777);

    reset_mid_move();
    run_cmd(3'd2, 3'd6, 3'd0, 0, 16'h0);

    for (int t = 0; t < 60; t++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
              int'($urandom_range(0, TMO + 1)), 16'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mem_valid = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
